// File: rtl/simplebus_pkg.sv
// Shared types and widths for the simplebus leader: FSM states, bus widths
// and the byte lanes the 24-bit request address is split into.
package simplebus_pkg;

  localparam int ADDR_W     = 24;
  localparam int DATA_W     = 8;
  localparam int BUS_ADDR_W = 8;

  localparam int ADDR_UP_LSB  = 16;
  localparam int ADDR_MID_LSB = 8;
  localparam int ADDR_LO_LSB  = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR_UP,
    ST_ADDR_MID,
    ST_ADDR_LO,
    ST_WRITE,
    ST_READ_WAIT,
    ST_RESP
  } leader_state_t;

  function automatic logic [BUS_ADDR_W-1:0] addr_byte(input logic [ADDR_W-1:0] a,
                                                      input int lsb);
    return a[lsb +: BUS_ADDR_W];
  endfunction

endpackage

// File: rtl/simplebus_timeout_ctr.sv
// Read-wait timer: counts cycles while enabled and flags the last allowed
// cycle so the leader gives up on a follower that never answers.
module simplebus_timeout_ctr #(
  parameter int TIMEOUT = 32
) (
  input  logic clock,
  input  logic resetN,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_last;

  // Count holds 0 during the first waiting cycle, so LAST marks cycle TIMEOUT.
  assign w_last    = (r_count == LAST);
  assign o_expired = i_enable && w_last;

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !w_last) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule

// File: rtl/simplebus_leader_ctrl.sv
// simplebus leader: turns 24-bit read/write requests into the three-phase
// address sequence, a write data cycle or a bounded read wait, and one response.
module simplebus_leader_ctrl
  import simplebus_pkg::*;
#(
  parameter int TIMEOUT = 32
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_read,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [DATA_W-1:0]     req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic                  rsp_error,
  output logic                  start,
  output logic                  read,
  output logic [BUS_ADDR_W-1:0] address,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_oe,
  input  logic                  dv_in,
  output logic                  dv_out,
  output logic                  dv_oe
);

  leader_state_t     r_state;
  leader_state_t     w_next;
  logic              r_read;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_error;
  logic              w_accept;
  logic              w_waiting;
  logic              w_expired;

  assign w_accept  = req_valid && (r_state == ST_IDLE);
  assign w_waiting = (r_state == ST_READ_WAIT);

  // Held in clear outside READ_WAIT, so every wait starts from zero.
  simplebus_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clock     (clock),
    .resetN    (resetN),
    .i_clear   (!w_waiting),
    .i_enable  (w_waiting),
    .o_expired (w_expired)
  );

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Request fields only matter once accepted; no reset needed.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_read  <= req_read;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_rdata <= '0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        ST_WRITE: begin
          r_rdata <= '0;
          r_error <= 1'b0;
        end
        ST_READ_WAIT: begin
          // Data beats the timeout when both land on the same edge.
          if (dv_in) begin
            r_rdata <= data_in;
            r_error <= 1'b0;
          end else if (w_expired) begin
            r_rdata <= '0;
            r_error <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next    = r_state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    start     = 1'b0;
    read      = 1'b0;
    address   = '0;
    data_out  = '0;
    data_oe   = 1'b0;
    dv_out    = 1'b0;
    dv_oe     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_next = ST_ADDR_UP;
      end
      ST_ADDR_UP: begin
        start   = 1'b1;
        address = addr_byte(r_addr, ADDR_UP_LSB);
        w_next  = ST_ADDR_MID;
      end
      ST_ADDR_MID: begin
        address = addr_byte(r_addr, ADDR_MID_LSB);
        w_next  = ST_ADDR_LO;
      end
      ST_ADDR_LO: begin
        address = addr_byte(r_addr, ADDR_LO_LSB);
        read    = r_read;
        w_next  = r_read ? ST_READ_WAIT : ST_WRITE;
      end
      ST_WRITE: begin
        data_out = r_wdata;
        data_oe  = 1'b1;
        dv_out   = 1'b1;
        dv_oe    = 1'b1;
        w_next   = ST_RESP;
      end
      ST_READ_WAIT: begin
        if (dv_in || w_expired) w_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign rsp_rdata = r_rdata;
  assign rsp_error = r_error;

endmodule

// File: tb/tb_simplebus_leader_ctrl.sv
// Directed bench for simplebus_leader_ctrl: a memory follower at id 01 on the
// main instance, plus a TIMEOUT=4 instance for the timeout/data tie cases.
module tb_simplebus_leader_ctrl;

  logic        clock;
  logic        resetN;
  logic        req_valid, req_ready, req_read;
  logic [23:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid, rsp_ready, rsp_error;
  logic [7:0]  rsp_rdata;
  logic        start, read;
  logic [7:0]  address, data_in, data_out;
  logic        data_oe, dv_in, dv_out, dv_oe;

  logic        req_valid_b, req_ready_b, req_read_b;
  logic [23:0] req_addr_b;
  logic [7:0]  req_wdata_b;
  logic        rsp_valid_b, rsp_ready_b, rsp_error_b;
  logic [7:0]  rsp_rdata_b;
  logic        start_b, read_b;
  logic [7:0]  address_b, data_in_b, data_out_b;
  logic        data_oe_b, dv_in_b, dv_out_b, dv_oe_b;

  int n_tests = 0;
  int n_fail  = 0;

  simplebus_leader_ctrl #(.TIMEOUT(32)) dut (
    .clock(clock), .resetN(resetN),
    .req_valid(req_valid), .req_ready(req_ready), .req_read(req_read),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_error(rsp_error), .start(start), .read(read), .address(address),
    .data_in(data_in), .data_out(data_out), .data_oe(data_oe),
    .dv_in(dv_in), .dv_out(dv_out), .dv_oe(dv_oe)
  );

  simplebus_leader_ctrl #(.TIMEOUT(4)) dut_b (
    .clock(clock), .resetN(resetN),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_read(req_read_b),
    .req_addr(req_addr_b), .req_wdata(req_wdata_b),
    .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
    .rsp_error(rsp_error_b), .start(start_b), .read(read_b), .address(address_b),
    .data_in(data_in_b), .data_out(data_out_b), .data_oe(data_oe_b),
    .dv_in(dv_in_b), .dv_out(dv_out_b), .dv_oe(dv_oe_b)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  // Memory follower with id 01: snoops the address phases, stores write
  // data, answers reads f_delay edges after the low address byte.
  logic [7:0]  mem [logic [15:0]];
  logic [23:0] f_addr;
  int          f_phase, f_cnt;
  int          f_delay = 2;
  int          n_starts = 0;
  logic        s_start, s_read, s_doe, s_dvoe, s_dvo;
  logic [7:0]  s_addr, s_dout;

  initial begin
    f_phase = 0;
    f_cnt   = 0;
    f_addr  = '0;
    dv_in   = 1'b0;
    data_in = 8'h00;
    forever begin
      @(posedge clock);
      s_start = start;  s_addr = address; s_read = read;
      s_doe   = data_oe; s_dvoe = dv_oe;  s_dvo  = dv_out; s_dout = data_out;
      #1;
      dv_in   = 1'b0;
      data_in = 8'h00;
      if (!resetN) begin
        f_phase = 0;
      end else begin
        case (f_phase)
          0: if (s_start) begin f_addr[23:16] = s_addr; f_phase = 1; n_starts++; end
          1: begin f_addr[15:8] = s_addr; f_phase = 2; end
          2: begin
            f_addr[7:0] = s_addr;
            if (f_addr[23:16] != 8'h01) f_phase = 0;
            else if (s_read) begin f_cnt = f_delay; f_phase = 4; end
            else f_phase = 3;
          end
          3: begin
            if (s_doe && s_dvoe && s_dvo) mem[f_addr[15:0]] = s_dout;
            f_phase = 0;
          end
          4: begin
            if (f_cnt <= 1) begin
              dv_in   = 1'b1;
              data_in = mem.exists(f_addr[15:0]) ? mem[f_addr[15:0]] : 8'h00;
              f_phase = 0;
            end else begin
              f_cnt--;
            end
          end
          default: f_phase = 0;
        endcase
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // {req_ready, rsp_valid, rsp_error, start, read, data_oe, dv_oe, dv_out}
  function automatic logic [7:0] ctl_a();
    return {req_ready, rsp_valid, rsp_error, start, read, data_oe, dv_oe, dv_out};
  endfunction

  task automatic run_req(input logic rd, input logic [23:0] a, input logic [7:0] wd,
                         output int lat, output int idle_viol);
    @(negedge clock);
    req_valid = 1'b1; req_read = rd; req_addr = a; req_wdata = wd;
    @(posedge clock);
    #1 req_valid = 1'b0;
    lat = 0;
    idle_viol = 0;
    while (!rsp_valid && lat < 200) begin
      @(posedge clock);
      #1 lat++;
      if (!rsp_valid && lat >= 3 &&
          (start || read || address != 8'h00 || data_oe || dv_oe)) idle_viol++;
    end
  endtask

  task automatic accept_rsp(input string tag);
    @(negedge clock);
    rsp_ready = 1'b1;
    @(posedge clock);
    #1 rsp_ready = 1'b0;
    check({tag, "_to_idle"}, {30'd0, req_ready, rsp_valid}, 32'b10);
  endtask

  int lat, viol, bad, starts0, d;

  initial begin
    resetN = 1'b0;
    req_valid = 0; req_read = 0; req_addr = '0; req_wdata = '0; rsp_ready = 0;
    req_valid_b = 0; req_read_b = 0; req_addr_b = '0; req_wdata_b = '0; rsp_ready_b = 0;
    dv_in_b = 0; data_in_b = '0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset_ctl", ctl_a(), 8'b1000_0000);
    check("reset_data", {rsp_rdata, address, data_out}, 24'h0);
    resetN = 1'b1;

    // Write 010406 <- DC, checking each bus phase.
    @(negedge clock);
    req_valid = 1; req_read = 0; req_addr = 24'h010406; req_wdata = 8'hDC;
    @(posedge clock);
    #1 req_valid = 0;
    check("wr_addr_up", {ctl_a(), address}, {8'b0001_0000, 8'h01});
    @(posedge clock); #1;
    check("wr_addr_mid", {ctl_a(), address}, {8'b0000_0000, 8'h04});
    @(posedge clock); #1;
    check("wr_addr_lo", {ctl_a(), address}, {8'b0000_0000, 8'h06});
    @(posedge clock); #1;
    check("wr_data", {ctl_a(), data_out, address}, {8'b0000_0111, 8'hDC, 8'h00});
    @(posedge clock); #1;
    check("wr_rsp", {ctl_a(), rsp_rdata}, {8'b0100_0000, 8'h00});
    check("wr_follower_addr", f_addr, 24'h010406);
    accept_rsp("wr");

    // Read back with delay 2: rsp one edge after the dv_in sample.
    f_delay = 2;
    run_req(1'b1, 24'h010406, 8'h00, lat, viol);
    check("rd_lat_d2", lat, 6);
    check("rd_data_d2", {rsp_error, rsp_rdata}, {1'b0, 8'hDC});
    accept_rsp("rd_d2");

    run_req(1'b0, 24'h010010, 8'h5A, lat, viol);
    check("wr2_lat", lat, 4);
    accept_rsp("wr2");
    run_req(1'b0, 24'h010011, 8'hA5, lat, viol);
    accept_rsp("wr3");

    f_delay = 5;
    run_req(1'b1, 24'h010010, 8'h00, lat, viol);
    check("rd_lat_d5", lat, 9);
    check("rd_data_d5", {rsp_error, rsp_rdata}, {1'b0, 8'h5A});
    accept_rsp("rd_d5");

    f_delay = 9;
    run_req(1'b1, 24'h010011, 8'h00, lat, viol);
    check("rd_lat_d9", lat, 13);
    check("rd_data_d9", {rsp_error, rsp_rdata}, {1'b0, 8'hA5});
    accept_rsp("rd_d9");

    d = $urandom_range(2, 9);
    f_delay = d;
    run_req(1'b1, 24'h010406, 8'h00, lat, viol);
    check("rd_lat_rand", lat, 4 + d);
    check("rd_data_rand", {rsp_error, rsp_rdata}, {1'b0, 8'hDC});
    accept_rsp("rd_rand");

    // Unmapped read: 32 wait cycles, then error with zero data, bus idle.
    run_req(1'b1, 24'h050000, 8'h00, lat, viol);
    check("unm_lat", lat, 35);
    check("unm_rsp", {rsp_error, rsp_rdata}, {1'b1, 8'h00});
    check("unm_bus_idle", viol, 0);
    accept_rsp("unm");

    // Backpressure with a pending request waiting behind the response.
    f_delay = 3;
    run_req(1'b1, 24'h010406, 8'h00, lat, viol);
    starts0 = n_starts;
    @(negedge clock);
    req_valid = 1; req_read = 0; req_addr = 24'h010050; req_wdata = 8'h11;
    bad = 0;
    repeat (10) begin
      @(posedge clock); #1;
      if (!rsp_valid || rsp_rdata != 8'hDC || rsp_error || req_ready || start) bad++;
    end
    check("bp_stable", bad, 0);
    check("bp_no_start", n_starts, starts0);
    @(negedge clock);
    rsp_ready = 1;
    @(posedge clock);
    #1 rsp_ready = 0;
    check("bp_release", {ctl_a(), address}, {8'b1000_0000, 8'h00});
    @(negedge clock);
    req_valid = 0;
    repeat (3) @(posedge clock);
    #1;
    check("bp_no_accept", n_starts, starts0);

    // Reset in the middle of a read wait.
    @(negedge clock);
    req_valid = 1; req_read = 1; req_addr = 24'h050000;
    @(posedge clock);
    #1 req_valid = 0;
    repeat (5) @(posedge clock);
    #3 resetN = 0;
    #1;
    check("rst_mid_ctl", ctl_a(), 8'b1000_0000);
    check("rst_mid_data", {rsp_rdata, address, data_out}, 24'h0);
    repeat (2) @(posedge clock);
    @(negedge clock);
    resetN = 1;
    bad = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (rsp_valid || !req_ready) bad++;
    end
    check("rst_no_rsp", bad, 0);
    run_req(1'b0, 24'h010030, 8'h6E, lat, viol);
    check("rst_next_lat", lat, 4);
    check("rst_next_rsp", {rsp_error, rsp_rdata}, {1'b0, 8'h00});
    accept_rsp("rst_next");

    // TIMEOUT=4: data on the 4th wait cycle beats the timeout.
    @(negedge clock);
    req_valid_b = 1; req_read_b = 1; req_addr_b = 24'h020001;
    @(posedge clock);
    #1 req_valid_b = 0;
    repeat (6) @(posedge clock);
    #1;
    check("tie_not_yet", rsp_valid_b, 1'b0);
    @(negedge clock);
    dv_in_b = 1; data_in_b = 8'h3C;
    @(posedge clock);
    #1 dv_in_b = 0; data_in_b = 8'h00;
    check("tie_rsp", {rsp_valid_b, rsp_error_b, rsp_rdata_b}, {1'b1, 1'b0, 8'h3C});
    @(negedge clock);
    rsp_ready_b = 1;
    @(posedge clock);
    #1 rsp_ready_b = 0;
    check("tie_to_idle", {req_ready_b, rsp_valid_b}, 2'b10);

    // TIMEOUT=4: dv_in during address phases is ignored, so it times out.
    @(negedge clock);
    req_valid_b = 1; req_read_b = 1; req_addr_b = 24'h020002;
    @(posedge clock);
    #1 req_valid_b = 0; dv_in_b = 1; data_in_b = 8'hFF;
    repeat (3) @(posedge clock);
    #1 dv_in_b = 0; data_in_b = 8'h00;
    lat = 3;
    while (!rsp_valid_b && lat < 100) begin
      @(posedge clock);
      #1 lat++;
    end
    check("to4_lat", lat, 7);
    check("to4_rsp", {rsp_error_b, rsp_rdata_b}, {1'b1, 8'h00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
